// File: rtl/data_memory_unit_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_unit_pkg
// Shared definitions for the data memory stage and the control unit:
//   - RV32 load/store FUNCT3 encodings (LB..LHU, SB..SW)
//   - FSM state encodings for the multi-cycle data memory (IDLE/ACCESS/DONE)
//   - helpers that turn FUNCT3 and the low address bits into an access size,
//     a byte-lane write mask and lane-replicated store data
// Optional feature macro used by the importers: DATA_MEM_MISALIGN_TRAP_EN
// -----------------------------------------------------------------------------
package data_memory_unit_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  // Unused encodings (011, 110, 111) fall through to a word access.
  function automatic size_e access_size(input logic [2:0] funct3);
    case (funct3)
      F3_LB, F3_LBU: return SZ_BYTE;
      F3_LH, F3_LHU: return SZ_HALF;
      default:       return SZ_WORD;
    endcase
  endfunction

  // Byte lanes touched by an access; halfwords ignore off[0] and words
  // ignore off[1:0], so accesses are always forced aligned.
  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so each lane just takes its own byte.
  function automatic logic [31:0] lane_data(input size_e sz, input logic [31:0] wdata);
    case (sz)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_unit_load_align.sv
// -----------------------------------------------------------------------------
// mem_load_align
// Combinational load formatter: picks the byte or halfword addressed by
// byte_off out of a 32-bit memory word and sign- or zero-extends it according
// to funct3. Halfwords use byte_off[1] only, words ignore byte_off.
// Ports:
//   word_in   [31:0] in   aligned memory word
//   byte_off  [1:0]  in   address bits [1:0] of the access
//   funct3    [2:0]  in   load encoding (LB/LH/LW/LBU/LHU, others = word)
//   data_out  [31:0] out  extended load result
// -----------------------------------------------------------------------------
module mem_load_align
  import data_memory_unit_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;

  always_comb begin
    case (byte_off)
      2'd0:    byte_sel = word_in[7:0];
      2'd1:    byte_sel = word_in[15:8];
      2'd2:    byte_sel = word_in[23:16];
      default: byte_sel = word_in[31:24];
    endcase
    half_sel = byte_off[1] ? word_in[31:16] : word_in[15:0];
    // funct3[2] distinguishes the unsigned variants (LBU/LHU)
    sign_ext = ~funct3[2];

    case (access_size(funct3))
      SZ_BYTE: data_out = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: data_out = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: data_out = word_in;
    endcase
  end

endmodule

// File: rtl/data_memory_unit.sv
// -----------------------------------------------------------------------------
// data_memory_unit
// Multi-cycle, byte-addressed data memory answering MEM_READ / MEM_WRITE from
// the MEM stage. A request in IDLE latches the operands, spends LATENCY cycles
// in ACCESS, performs the access on the last ACCESS edge and spends one cycle
// in DONE with BUSY_WAIT low so the pipeline advances.
// Ports:
//   CLK            in   clock, rising edge
//   RESET          in   synchronous active-low reset
//   MEM_READ       in   load request
//   MEM_WRITE      in   store request (wins if both strobes are high)
//   FUNCT3 [2:0]   in   access size/sign
//   ADDRESS [31:0] in   byte address (bits >= ADDR_WIDTH aliased)
//   WRITE_DATA[31:0] in store data
//   READ_DATA[31:0] out registered extended load result
//   BUSY_WAIT      out  stall request
//   MISALIGNED     out  only with DATA_MEM_MISALIGN_TRAP_EN: one-cycle flag in
//                       DONE for a misaligned H/W access (access suppressed)
// Without DATA_MEM_MISALIGN_TRAP_EN, H/W accesses are forced aligned.
// Storage is four byte-wide banks (one per lane) with registered read.
// -----------------------------------------------------------------------------
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY_WAIT
`ifdef DATA_MEM_MISALIGN_TRAP_EN
  ,
  output logic        MISALIGNED
`endif
);

  localparam int         WIDX_W   = ADDR_WIDTH - 2;
  localparam int         WORDS    = 2 ** WIDX_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [3:0]              counter_q, counter_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [2:0]              funct3_q, funct3_d;
  logic                    is_store_q, is_store_d;
  logic [31:0]             read_data_q, read_data_d;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
  logic                    misaligned_q, misaligned_d;
`endif

  size_e                   op_size;
  logic                    access_ok;
  logic                    complete;
  logic                    request;
  logic [3:0]              wr_lanes;
  logic [31:0]             wr_lane_data;
  logic [WIDX_W-1:0]       wr_idx;
  logic [WIDX_W-1:0]       rd_idx;
  logic [31:0]             rd_word;
  logic [31:0]             load_value;

  // Address bits above ADDR_WIDTH alias onto the decoded range.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ADDRESS[31:ADDR_WIDTH];

  always_comb begin
    op_size  = access_size(funct3_q);
    complete = (state_q == ST_ACCESS) && (counter_q == 4'd0);
    request  = MEM_READ | MEM_WRITE;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    access_ok = !is_misaligned(op_size, addr_q[1:0]);
`else
    access_ok = 1'b1;
`endif
    // RESET gating drops the write if reset lands on the completing edge.
    wr_lanes     = (complete && is_store_q && access_ok && RESET)
                   ? lane_mask(op_size, addr_q[1:0]) : 4'b0000;
    wr_lane_data = lane_data(op_size, wdata_q);
    wr_idx       = addr_q[ADDR_WIDTH-1:2];
    // In IDLE the read port already tracks the incoming address so the word
    // is registered on the request edge; in ACCESS it tracks the latched one.
    rd_idx       = (state_q == ST_ACCESS) ? addr_q[ADDR_WIDTH-1:2]
                                          : ADDRESS[ADDR_WIDTH-1:2];
  end

  // Byte-lane storage banks, registered read.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] bank_mem [WORDS];
    logic [7:0] rd_byte_q;

    always_ff @(posedge CLK) begin
      if (wr_lanes[gi]) begin
        bank_mem[wr_idx] <= wr_lane_data[8*gi +: 8];
      end
      rd_byte_q <= bank_mem[rd_idx];
    end
  end

  assign rd_word = {g_lane[3].rd_byte_q, g_lane[2].rd_byte_q,
                    g_lane[1].rd_byte_q, g_lane[0].rd_byte_q};

  mem_load_align u_load_align (
    .word_in  (rd_word),
    .byte_off (addr_q[1:0]),
    .funct3   (funct3_q),
    .data_out (load_value)
  );

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    funct3_d    = funct3_q;
    is_store_d  = is_store_q;
    read_data_d = read_data_q;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    misaligned_d = 1'b0;
`endif
    BUSY_WAIT   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        BUSY_WAIT = request;
        if (request) begin
          addr_d     = ADDRESS[ADDR_WIDTH-1:0];
          wdata_d    = WRITE_DATA;
          funct3_d   = FUNCT3;
          is_store_d = MEM_WRITE;
          counter_d  = CNT_INIT;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        BUSY_WAIT = 1'b1;
        if (counter_q == 4'd0) begin
          if (!is_store_q && access_ok) begin
            read_data_d = load_value;
          end
`ifdef DATA_MEM_MISALIGN_TRAP_EN
          misaligned_d = !access_ok;
`endif
          state_d = ST_DONE;
        end else begin
          counter_d = counter_q - 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      counter_q   <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      funct3_q    <= 3'd0;
      is_store_q  <= 1'b0;
      read_data_q <= 32'd0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      funct3_q    <= funct3_d;
      is_store_q  <= is_store_d;
      read_data_q <= read_data_d;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  assign READ_DATA = read_data_q;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign MISALIGNED = misaligned_q;
`endif

endmodule

// File: tb/tb_data_memory_unit.sv
// -----------------------------------------------------------------------------
// tb_data_memory_unit
// Self-checking bench for data_memory_unit: a table of directed load/store
// vectors with hand-computed results, hand-written multi-cycle sequences
// (back-to-back loads, reset mid-transaction) and randomized traffic checked
// against a byte-array reference model.
// -----------------------------------------------------------------------------
module tb_data_memory_unit;

  localparam int LATENCY   = 4;
  localparam int MEM_BYTES = 1024;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic [31:0] READ_DATA;
  logic        BUSY_WAIT;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
  logic        MISALIGNED;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] model_rd;
  bit          model_mis;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  always #5 CLK = ~CLK;

  data_memory_unit #(
    .ADDR_WIDTH (10),
    .LATENCY    (LATENCY)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MEM_READ   (MEM_READ),
    .MEM_WRITE  (MEM_WRITE),
    .FUNCT3     (FUNCT3),
    .ADDRESS    (ADDRESS),
    .WRITE_DATA (WRITE_DATA),
    .READ_DATA  (READ_DATA),
    .BUSY_WAIT  (BUSY_WAIT)
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    ,
    .MISALIGNED (MISALIGNED)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.f3 = f3;
    v.addr = addr; v.wdata = wdata; v.exp = exp;
    vq.push_back(v);
  endtask

  // Behavioural model: a flat byte array, little-endian, addresses modulo
  // the decoded size, accesses rounded down to their natural alignment.
  task automatic model_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned sz;
    int unsigned a;
    longint unsigned v;
    if (f3 == 3'b000 || f3 == 3'b100)      sz = 1;
    else if (f3 == 3'b001 || f3 == 3'b101) sz = 2;
    else                                   sz = 4;
    a = addr % MEM_BYTES;
    model_mis = 1'b0;
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    if (a % sz != 0) begin
      model_mis = 1'b1;
      return;
    end
`endif
    a = a - (a % sz);
    if (wr) begin
      for (int i = 0; i < int'(sz); i++) ref_mem[a + i] = 8'(wdata >> (8 * i));
    end else if (rd) begin
      v = 0;
      for (int i = 0; i < int'(sz); i++) v = v | (longint'(ref_mem[a + i]) << (8 * i));
      if ((f3 == 3'b000 || f3 == 3'b001) && v[8 * sz - 1]) v = v | ~((64'd1 << (8 * sz)) - 1);
      model_rd = v[31:0];
    end
  endtask

  // Issues one request, scrambles the inputs during ACCESS, counts the
  // BUSY_WAIT-high cycles and checks READ_DATA in DONE.
  task automatic txn(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp_rd);
    int n_busy;
    bit done;
    MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = addr; WRITE_DATA = wdata;
    n_busy = 0;
    done   = 1'b0;
    for (int c = 0; c < 3 * LATENCY + 8 && !done; c++) begin
      @(negedge CLK);
      if (BUSY_WAIT === 1'b1) begin
        n_busy++;
        @(posedge CLK); #1;
        if (c == 0) begin
          MEM_READ = 1'b0; MEM_WRITE = 1'b0;
          FUNCT3 = 3'($urandom); ADDRESS = $urandom; WRITE_DATA = $urandom;
        end
      end else begin
        done = 1'b1;
      end
    end
    check({name, "/busy_cycles"}, n_busy, LATENCY + 1);
    check({name, "/read_data"}, READ_DATA, exp_rd);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    check({name, "/misaligned"}, {31'd0, MISALIGNED}, {31'd0, model_mis});
`endif
    $display("txn %-14s rd=%0b wr=%0b f3=%03b addr=%08h wdata=%08h read_data=%08h busy=%0d",
             name, rd, wr, f3, addr, wdata, READ_DATA, n_busy);
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic run_exp(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] exp);
    model_op(rd, wr, f3, addr, wdata);
    txn(name, rd, wr, f3, addr, wdata, exp);
  endtask

  task automatic run(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata);
    model_op(rd, wr, f3, addr, wdata);
    txn(name, rd, wr, f3, addr, wdata, model_rd);
  endtask

  logic [31:0] prev_rd, r1, r2, exp_rd_c;
  logic        exp_busy_c;
  int          op;

  initial begin
    RESET = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    FUNCT3 = 3'd0; ADDRESS = 32'd0; WRITE_DATA = 32'd0;
    model_rd = 32'd0; model_mis = 1'b0;

    // Reset for two edges
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset/busy", {31'd0, BUSY_WAIT}, 32'd0);
    check("reset/read_data", READ_DATA, 32'd0);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    check("reset/misaligned", {31'd0, MISALIGNED}, 32'd0);
`endif
    RESET = 1'b1;
    @(posedge CLK); #1;

    // Directed vectors (all naturally aligned)
    add_vec("sw_10",       0, 1, 3'b010, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000);
    add_vec("lw_10",       1, 0, 3'b010, 32'h0000_0010, 32'h0,        32'hDEADBEEF);
    add_vec("lb_10",       1, 0, 3'b000, 32'h0000_0010, 32'h0,        32'hFFFFFFEF);
    add_vec("lbu_11",      1, 0, 3'b100, 32'h0000_0011, 32'h0,        32'h000000BE);
    add_vec("lh_12",       1, 0, 3'b001, 32'h0000_0012, 32'h0,        32'hFFFFDEAD);
    add_vec("lhu_12",      1, 0, 3'b101, 32'h0000_0012, 32'h0,        32'h0000DEAD);
    add_vec("sb_13",       0, 1, 3'b000, 32'h0000_0013, 32'h00000011, 32'h0000DEAD);
    add_vec("lw_10_sb",    1, 0, 3'b010, 32'h0000_0010, 32'h0,        32'h11ADBEEF);
    add_vec("rdwr_sw_14",  1, 1, 3'b010, 32'h0000_0014, 32'hCAFEF00D, 32'h11ADBEEF);
    add_vec("lw_414_alias",1, 0, 3'b010, 32'h0000_0414, 32'h0,        32'hCAFEF00D);
    add_vec("lb_15",       1, 0, 3'b000, 32'h0000_0015, 32'h0,        32'hFFFFFFF0);
    add_vec("lhu_16",      1, 0, 3'b101, 32'h0000_0016, 32'h0,        32'h0000CAFE);
    add_vec("sh_16",       0, 1, 3'b001, 32'h0000_0016, 32'hAAAA5678, 32'h0000CAFE);
    add_vec("f3_011_alias",1, 0, 3'b011, 32'hFFFF_FC14, 32'h0,        32'h5678F00D);
    add_vec("f3_111",      1, 0, 3'b111, 32'h0000_0010, 32'h0,        32'h11ADBEEF);
    add_vec("lbu_17",      1, 0, 3'b100, 32'h0000_0017, 32'h0,        32'h00000056);
    foreach (vq[i]) run_exp(vq[i].name, vq[i].rd, vq[i].wr, vq[i].f3, vq[i].addr, vq[i].wdata, vq[i].exp);

`ifndef DATA_MEM_MISALIGN_TRAP_EN
    // Forced alignment of halfword/word accesses
    run_exp("lh_13_align",  1, 0, 3'b001, 32'h13, 32'h0,        32'h000011AD);
    run_exp("lw_17_align",  1, 0, 3'b010, 32'h17, 32'h0,        32'h5678F00D);
    run_exp("sw_1b_align",  0, 1, 3'b010, 32'h1B, 32'h01020304, 32'h5678F00D);
    run_exp("lw_18",        1, 0, 3'b010, 32'h18, 32'h0,        32'h01020304);
    run_exp("sh_19_align",  0, 1, 3'b001, 32'h19, 32'h0000BEEF, 32'h01020304);
    run_exp("lw_18_sh",     1, 0, 3'b010, 32'h18, 32'h0,        32'h0102BEEF);
`endif

    // Back-to-back loads with MEM_READ held high
    prev_rd = model_rd;
    model_op(1, 0, 3'b010, 32'h10, 32'h0); r1 = model_rd;
    model_op(1, 0, 3'b000, 32'h14, 32'h0); r2 = model_rd;
    MEM_READ = 1'b1; MEM_WRITE = 1'b0; FUNCT3 = 3'b010; ADDRESS = 32'h10;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      exp_busy_c = !(c == 5 || c == 11);
      exp_rd_c   = (c < 5) ? prev_rd : (c < 11) ? r1 : r2;
      check($sformatf("b2b/busy_c%0d", c), {31'd0, BUSY_WAIT}, {31'd0, exp_busy_c});
      check($sformatf("b2b/read_data_c%0d", c), READ_DATA, exp_rd_c);
      $display("b2b cycle %0d busy=%0b read_data=%08h", c, BUSY_WAIT, READ_DATA);
      @(posedge CLK); #1;
      if (c == 0) begin FUNCT3 = 3'b000; ADDRESS = 32'h14; end
    end
    MEM_READ = 1'b0;

    // Reset in the 2nd ACCESS cycle of a store
    run_exp("sw_20_pre", 0, 1, 3'b010, 32'h20, 32'h0BADF00D, model_rd);
    MEM_WRITE = 1'b1; FUNCT3 = 3'b010; ADDRESS = 32'h20; WRITE_DATA = 32'h12345678;
    @(posedge CLK); #1;
    MEM_WRITE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("midreset/busy", {31'd0, BUSY_WAIT}, 32'd0);
    check("midreset/read_data", READ_DATA, 32'd0);
    $display("midreset busy=%0b read_data=%08h", BUSY_WAIT, READ_DATA);
    RESET = 1'b1;
    model_rd = 32'd0;
    @(posedge CLK); #1;
    run_exp("lw_20_after", 1, 0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D);

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    run_exp("lw_12_mis", 1, 0, 3'b010, 32'h12, 32'h0, 32'h0BADF00D);
    @(negedge CLK);
    check("lw_12_mis/clear", {31'd0, MISALIGNED}, 32'd0);
    @(posedge CLK); #1;
    run_exp("sh_21_mis", 0, 1, 3'b001, 32'h21, 32'h0000FFFF, 32'h0BADF00D);
    run_exp("lw_20_chk", 1, 0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D);
`endif

    // Randomized traffic in 0x40..0x7F, with random aliased upper bits
    for (int i = 0; i < 16; i++) run("init", 0, 1, 3'b010, 32'h40 + 32'(4 * i), $urandom);
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      run("rand", op != 1, op != 0, 3'($urandom_range(0, 7)),
          {22'($urandom), 10'h40 + 10'($urandom_range(0, 63))}, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
